// File: rtl/mdu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mdu_arbiter
// Brief    : Round-robin arbiter sharing one multi-cycle multiply/divide unit
//            between the integer pipe (req0) and the microcode/CSR sequencer
//            (req1). Sequences the MDU via start/done and returns tagged
//            results, discarding results of flushed requests.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_arbiter #(
  parameter int XLEN = 64,
  parameter int OPW  = 9,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OPW-1:0]  req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [TAGW-1:0] req0_tag,
  input  logic            flush0,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OPW-1:0]  req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  input  logic [TAGW-1:0] req1_tag,
  input  logic            flush1,
  output logic            mdu_start,
  output logic [OPW-1:0]  mdu_op,
  output logic [XLEN-1:0] mdu_a,
  output logic [XLEN-1:0] mdu_b,
  input  logic            mdu_done,
  input  logic [XLEN-1:0] mdu_result,
  output logic            rsp_valid,
  output logic            rsp_id,
  output logic [TAGW-1:0] rsp_tag,
  output logic [XLEN-1:0] rsp_result,
  input  logic            rsp_ready,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_prio;
  logic              r_kill;
  logic              r_id;
  logic              r_start;
  logic              r_rsp_valid;
  logic [OPW-1:0]    r_op;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [TAGW-1:0]   r_tag;
  logic [XLEN-1:0]   r_result;

  logic              w_idle;
  logic              w_elig0;
  logic              w_elig1;
  logic              w_gnt_any;
  logic              w_gnt_id;
  logic              w_flush_own;
  logic [OPW-1:0]    w_sel_op;
  logic [XLEN-1:0]   w_sel_a;
  logic [XLEN-1:0]   w_sel_b;
  logic [TAGW-1:0]   w_sel_tag;

  // Grant selection: a flushed requester is never eligible; prio breaks ties.
  always_comb begin
    w_idle      = (r_state == S_IDLE);
    w_elig0     = req0_valid & ~flush0;
    w_elig1     = req1_valid & ~flush1;
    w_gnt_any   = w_elig0 | w_elig1;
    w_gnt_id    = (w_elig0 & w_elig1) ? r_prio : w_elig1;
    w_flush_own = r_id ? flush1 : flush0;
    w_sel_op    = w_gnt_id ? req1_op  : req0_op;
    w_sel_a     = w_gnt_id ? req1_a   : req0_a;
    w_sel_b     = w_gnt_id ? req1_b   : req0_b;
    w_sel_tag   = w_gnt_id ? req1_tag : req0_tag;
  end

  // Ready is gated by rst_n so every output reads 0 while reset is held.
  assign req0_ready = rst_n & w_idle & w_gnt_any & ~w_gnt_id;
  assign req1_ready = rst_n & w_idle & w_gnt_any &  w_gnt_id;

  // Control FSM: grant, start pulse, wait for done, hold response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_prio      <= 1'b0;
      r_kill      <= 1'b0;
      r_id        <= 1'b0;
      r_start     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_tag       <= '0;
      r_result    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_kill <= 1'b0;
          if (w_gnt_any) begin
            r_op   <= w_sel_op;
            r_a    <= w_sel_a;
            r_b    <= w_sel_b;
            r_tag  <= w_sel_tag;
            r_id   <= w_gnt_id;
            r_prio <= ~w_gnt_id;
            if (w_sel_op == '0) begin
              // Null op: answer with zero without touching the MDU.
              r_result    <= '0;
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end else begin
              r_start <= 1'b1;
              r_state <= S_START;
            end
          end
        end
        S_START: begin
          // The start pulse always completes; a flush only marks the op dead.
          r_start <= 1'b0;
          r_state <= S_WAIT;
          if (w_flush_own) r_kill <= 1'b1;
        end
        S_WAIT: begin
          if (mdu_done) begin
            r_result <= mdu_result;
            if (r_kill | w_flush_own) begin
              r_kill  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end
          end else if (w_flush_own) begin
            r_kill <= 1'b1;
          end
        end
        S_RESP: begin
          // Owner flush drops the response; no re-grant in the same cycle.
          if (w_flush_own | rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mdu_start  = r_start;
  assign mdu_op     = r_op;
  assign mdu_a      = r_a;
  assign mdu_b      = r_b;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_id;
  assign rsp_tag    = r_tag;
  assign rsp_result = r_result;
  assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/mdu_arbiter.md
Name: mdu_arbiter

Overview:
- Shares one multi-cycle multiply/divide unit (MDU) between two requesters: req0 is the integer pipe, req1 is the microcode/CSR sequencer.
- Arbitrates round-robin and sequences the MDU through a start/done handshake.
- Returns each result to its owner with a tag, and discards results of flushed requests.
- Sits between the execute-stage issue logic and the MDU datapath.

Parameters:
- XLEN, 64, operand/result width
- OPW, 9, op field width: {mul_op[4:0], div_op[3:0]}, passed through unmodified
- TAGW, 4, requester tag width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an op
- req0_ready  out  1  requester 0 op accepted this cycle
- req0_op  in  OPW  op encoding
- req0_a, req0_b  in  XLEN  operands
- req0_tag  in  TAGW  tag
- flush0  in  1  kill any request owned by requester 0
- req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_tag, flush1  same as requester 0, for requester 1
- mdu_start  out  1  one-cycle start pulse to MDU
- mdu_op  out  OPW  latched op
- mdu_a, mdu_b  out  XLEN  latched operands
- mdu_done  in  1  MDU result valid (single-cycle pulse)
- mdu_result  in  XLEN  MDU result
- rsp_valid  out  1  response valid
- rsp_id  out  1  owner of response (0/1)
- rsp_tag  out  TAGW  owner's tag
- rsp_result  out  XLEN  result
- rsp_ready  in  1  response consumer ready
- busy  out  1  FSM not IDLE

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; prio=0 (req0 favoured); kill=0; op/a/b/tag/id/result registers 0.
- States:
  - IDLE: accepting.
  - START: mdu_start=1 for exactly one cycle.
  - WAIT: waiting for mdu_done.
  - RESP: holding response.
- IDLE grant:
  - eligible_i = req_i_valid & ~flush_i.
  - If both are eligible, grant the one selected by prio; otherwise grant the sole eligible one.
  - reqX_ready = 1 combinationally only for the granted requester, only in IDLE.
  - On grant: latch op/a/b/tag/id; prio <= ~id.
- Null op: if the granted op has no bit set, no MDU start. Go directly to RESP with rsp_result=0; rsp_valid asserts the next cycle.
- Otherwise IDLE -> START -> WAIT.
  - mdu_op/mdu_a/mdu_b are stable from START until leaving WAIT.
- WAIT: on mdu_done, capture mdu_result.
  - If kill=0: -> RESP.
  - If kill=1: -> IDLE, kill<=0, no response.
- RESP:
  - rsp_valid=1; rsp_id/tag/result are stable until rsp_ready.
  - rsp_valid & rsp_ready -> IDLE. There is no same-cycle re-grant; the next accept is the following cycle.
- Latency: accept at cycle T; mdu_start at T+1; mdu_done at D >= T+2; rsp_valid at D+1. Minimum accept-to-accept spacing is 4 cycles plus MDU time.
- Flush matching owner id:
  - In START or WAIT: set kill. START still completes; the MDU is never aborted mid-operation.
  - In RESP: drop the response, -> IDLE this cycle; rsp_valid goes low next cycle.
  - In IDLE: the flushed requester is not eligible that cycle.
  - Flush of the non-owner: no effect on the in-flight op.
  - flush0 and flush1 together: owner is killed; nothing is granted that cycle.
- mdu_done outside WAIT is ignored (protocol error). The bench asserts it never occurs.
- Asynchronous reset mid-operation returns to IDLE and drops any response. The MDU is reset by the same rst_n.
- busy = (state != IDLE).

Test Plan:
- req0 only, op=mul, a=3, b=5; MDU returns 15 three cycles after start -> req0_ready at T, mdu_start at T+1 only, rsp_valid with id=0, result=15 at done+1, held 2 cycles while rsp_ready=0.
- req0 and req1 valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1; first grant is req0 after reset; tags are returned in order.
- Null op (op=0) on req1, tag=7 -> no mdu_start; rsp_valid next cycle with id=1, tag=7, result=0.
- flush0 in WAIT for a req0 div; MDU later returns 0x1234 -> no rsp_valid; FSM returns to IDLE; pending req1 is granted the following cycle.
- flush1 during RESP for req1 with rsp_ready=0 -> response dropped, rsp_valid low next cycle; flush0 in the same cycle has no effect on that response.
- rst_n asserted low in WAIT -> all outputs 0 immediately; after release, req1 alone is accepted normally (prio reset to 0, req1 is the sole requester).
